// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath widths, base opcodes and the
// immediate-format classification used by the decoder and immediate generator.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator.
// Ports:
//   instr    - 32-bit instruction word
//   imm_type - immediate format selected by the opcode (IMM_NONE for OP and
//              for unsupported opcodes)
//   imm      - immediate, sign-extended from instr[31]; zero for IMM_NONE
module imm_gen #(
  parameter int unsigned XLEN = rv32_pkg::XLEN
) (
  input  logic [31:0]         instr,
  output rv32_pkg::imm_type_e imm_type,
  output logic [XLEN-1:0]     imm
);
  import rv32_pkg::*;

  logic [31:0] imm32;

  always_comb begin
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
      OPC_STORE:                      imm_type = IMM_S;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_JAL:                        imm_type = IMM_J;
      default:                        imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.  Takes one instruction per cycle from fetch
// over a valid/ready handshake, addresses the register file combinationally,
// and registers decoded fields plus operands into the ID/EX register.
// Write-back data is bypassed into operands at capture time and into held
// operands while execute stalls.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   flush               - drop the held and the incoming instruction
//   if_valid/if_ready   - fetch handshake; if_instr, if_pc instruction and PC
//   rf_read_reg_1/2     - register-file read addresses (rs1, rs2)
//   rf_read_data_1/2    - register-file read data
//   wb_write_*          - write-back port (enable, register, data)
//   ex_valid/ex_ready   - execute handshake
//   ex_*                - registered decode outputs
module id_stage #(
  parameter int unsigned XLEN = rv32_pkg::XLEN,
  parameter int unsigned RA_W = rv32_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [RA_W-1:0] rf_read_reg_1,
  output logic [RA_W-1:0] rf_read_reg_2,
  input  logic [XLEN-1:0] rf_read_data_1,
  input  logic [XLEN-1:0] rf_read_data_2,
  input  logic            wb_write_enable,
  input  logic [RA_W-1:0] wb_write_reg,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_5,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            ex_illegal
);
  import rv32_pkg::*;

  // ID/EX register
  logic            valid_q,     valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [RA_W-1:0] rs1_q,       rs1_d;
  logic [RA_W-1:0] rs2_q,       rs2_d;
  logic [RA_W-1:0] rd_q,        rd_d;
  logic [6:0]      opcode_q,    opcode_d;
  logic [2:0]      funct3_q,    funct3_d;
  logic            funct7_5_q,  funct7_5_d;
  logic            reg_write_q, reg_write_d;
  logic            is_load_q,   is_load_d;
  logic            illegal_q,   illegal_d;

  // Decode of the presented instruction
  logic [6:0]      dec_opcode;
  logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
  imm_type_e       dec_imm_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_legal;
  logic            dec_writes_rd;
  logic            accept;

  assign dec_opcode    = if_instr[6:0];
  assign dec_rd        = if_instr[11:7];
  assign dec_rs1       = if_instr[19:15];
  assign dec_rs2       = if_instr[24:20];
  assign rf_read_reg_1 = dec_rs1;
  assign rf_read_reg_2 = dec_rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (if_instr),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  // OP is the only supported opcode without an immediate, so every other
  // IMM_NONE opcode is unsupported; imm_gen already yields 0 for those.
  assign dec_legal = (dec_imm_type != IMM_NONE) || (dec_opcode == OPC_OP);

  always_comb begin
    case (dec_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: dec_writes_rd = (dec_rd != '0);
      default:                      dec_writes_rd = 1'b0;
    endcase
  end

  assign if_ready = !valid_q || ex_ready;
  assign accept   = if_valid && if_ready && !flush;

  // Operand selection: x0 reads zero, then the same-cycle write-back value,
  // since the register file only commits that write at this edge.
  function automatic logic [XLEN-1:0] operand(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            wbe,
    input logic [RA_W-1:0] wbr,
    input logic [XLEN-1:0] wbd
  );
    if (rs == '0)
      return '0;
    else if (wbe && (wbr == rs))
      return wbd;
    else
      return rf_data;
  endfunction

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7_5_d  = funct7_5_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    illegal_d   = illegal_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      pc_d        = if_pc;
      rs1_data_d  = operand(dec_rs1, rf_read_data_1, wb_write_enable,
                            wb_write_reg, wb_write_data);
      rs2_data_d  = operand(dec_rs2, rf_read_data_2, wb_write_enable,
                            wb_write_reg, wb_write_data);
      imm_d       = dec_imm;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      rd_d        = dec_rd;
      opcode_d    = dec_opcode;
      funct3_d    = if_instr[14:12];
      funct7_5_d  = if_instr[30];
      reg_write_d = dec_writes_rd;
      is_load_d   = (dec_opcode == OPC_LOAD);
      illegal_d   = !dec_legal;
    end else if (valid_q && !ex_ready) begin
      // Stalled: keep operands current with registers written back meanwhile.
      if (wb_write_enable && (wb_write_reg != '0) && (wb_write_reg == rs1_q))
        rs1_data_d = wb_write_data;
      if (wb_write_enable && (wb_write_reg != '0) && (wb_write_reg == rs2_q))
        rs2_data_d = wb_write_data;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_5_q  <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7_5_q  <= funct7_5_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_opcode    = opcode_q;
  assign ex_funct3    = funct3_q;
  assign ex_funct7_5  = funct7_5_q;
  assign ex_reg_write = reg_write_q;
  assign ex_is_load   = is_load_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a
// behavioural model of the ID/EX register.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_read_reg_1, rf_read_reg_2;
  logic [31:0] rf_read_data_1, rf_read_data_2;
  logic        wb_write_enable;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_5, ex_reg_write, ex_is_load, ex_illegal;

  id_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected contents of the ID/EX register
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75, rw, ld, ill;
  } exp_t;

  exp_t m;

  function automatic logic [31:0] ref_operand(input int unsigned rs, input logic [31:0] rf,
                                              input logic wbe, input logic [4:0] wbr,
                                              input logic [31:0] wbd);
    if (rs == 0) return 32'h0;
    if (wbe && int'(wbr) == rs) return wbd;
    return rf;
  endfunction

  // Decode from the instruction-set definition using plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rd1, input logic [31:0] rd2,
                                      input logic wbe, input logic [4:0] wbr,
                                      input logic [31:0] wbd);
    exp_t e;
    int unsigned u, opc, rd, rs1, rs2;
    int s, imm;
    bit neg;
    u   = ins;
    s   = $signed(ins);
    neg = (s < 0);
    opc = u % 128;
    rd  = (u >> 7) % 32;
    rs1 = (u >> 15) % 32;
    rs2 = (u >> 20) % 32;
    imm = 0;
    e.ill = 1'b0;
    e.rw  = 1'b0;
    case (opc)
      'h03, 'h13, 'h67: imm = s >>> 20;
      'h23: imm = (s >>> 25) * 32 + int'(rd);
      'h63: imm = (neg ? -4096 : 0) + int'((u >> 7) % 2) * 2048
                  + int'((u >> 25) % 64) * 32 + int'((u >> 8) % 16) * 2;
      'h37, 'h17: imm = int'(u - (u % 4096));
      'h6F: imm = (neg ? -(1 << 20) : 0) + int'((u >> 12) % 256) * 4096
                  + int'((u >> 20) % 2) * 2048 + int'((u >> 21) % 1024) * 2;
      'h33: imm = 0;
      default: begin imm = 0; e.ill = 1'b1; end
    endcase
    if (opc inside {'h37, 'h17, 'h6F, 'h67, 'h03, 'h13, 'h33}) e.rw = (rd != 0);
    e.valid = 1'b1;
    e.pc    = pc;
    e.imm   = imm;
    e.rs1   = 5'(rs1);
    e.rs2   = 5'(rs2);
    e.rd    = 5'(rd);
    e.opc   = 7'(opc);
    e.f3    = 3'((u >> 12) % 8);
    e.f75   = 1'((u >> 30) % 2);
    e.ld    = (opc == 'h03);
    e.rs1d  = ref_operand(rs1, rd1, wbe, wbr, wbd);
    e.rs2d  = ref_operand(rs2, rd2, wbe, wbr, wbd);
    return e;
  endfunction

  function automatic exp_t ref_next(input exp_t cur);
    exp_t n = cur;
    logic rdy = !cur.valid || ex_ready;
    if (flush) n.valid = 1'b0;
    else if (if_valid && rdy)
      n = ref_decode(if_instr, if_pc, rf_read_data_1, rf_read_data_2,
                     wb_write_enable, wb_write_reg, wb_write_data);
    else if (cur.valid && !ex_ready) begin
      if (wb_write_enable && wb_write_reg != 0 && wb_write_reg == cur.rs1) n.rs1d = wb_write_data;
      if (wb_write_enable && wb_write_reg != 0 && wb_write_reg == cur.rs2) n.rs2d = wb_write_data;
    end else n.valid = 1'b0;
    return n;
  endfunction

  task automatic check_state(input bit all_fields);
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    if (m.valid || all_fields) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_data", ex_rs1_data, m.rs1d);
      chk("ex_rs2_data", ex_rs2_data, m.rs2d);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("ex_opcode", 32'(ex_opcode), 32'(m.opc));
      chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
      chk("ex_funct7_5", 32'(ex_funct7_5), 32'(m.f75));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
      chk("ex_is_load", 32'(ex_is_load), 32'(m.ld));
      chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
    end
  endtask

  // Called just after an edge with inputs already driven: checks the
  // combinational outputs, clocks once and checks the ID/EX register.
  task automatic tick();
    exp_t nxt;
    #1;
    chk("if_ready", 32'(if_ready), 32'(!m.valid || ex_ready));
    chk("rf_read_reg_1", 32'(rf_read_reg_1), (if_instr >> 15) % 32);
    chk("rf_read_reg_2", 32'(rf_read_reg_2), (if_instr >> 20) % 32);
    nxt = ref_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    check_state(1'b0);
  endtask

  task automatic idle_inputs();
    flush = 0; if_valid = 0; if_instr = 32'h0; if_pc = 32'h0;
    rf_read_data_1 = 32'h0; rf_read_data_2 = 32'h0;
    wb_write_enable = 0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
  endtask

  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd, e_imm, e_rs1d, e_rs2d;
    logic        e_rw, e_ill;
  } vec_t;

  vec_t vt[12];

  logic [6:0] opc_pool[10];

  initial begin
    vt[0]  = '{32'hFFD08293, 32'h1,  32'h77, 1'b0, 5'd0,  32'h0,        32'hFFFFFFFD, 32'h1,  32'h77,       1'b1, 1'b0}; // addi x5,x1,-3
    vt[1]  = '{32'h002081B3, 32'h11, 32'h2,  1'b1, 5'd2,  32'hDEADBEEF, 32'h0,        32'h11, 32'hDEADBEEF, 1'b1, 1'b0}; // add x3,x1,x2 bypass
    vt[2]  = '{32'h002081B3, 32'h11, 32'h2,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0,        32'h11, 32'h2,        1'b1, 1'b0}; // wb to x0 ignored
    vt[3]  = '{32'h000003B3, 32'h55, 32'h55, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,  32'h0,        1'b1, 1'b0}; // add x7,x0,x0
    vt[4]  = '{32'h00100013, 32'h3,  32'h9,  1'b0, 5'd0,  32'h0,        32'h1,        32'h0,  32'h9,        1'b0, 1'b0}; // addi x0,x0,1
    vt[5]  = '{32'hFFFFFFFF, 32'hA,  32'hB,  1'b0, 5'd0,  32'h0,        32'h0,        32'hA,  32'hB,        1'b0, 1'b1}; // opcode 0x7F
    vt[6]  = '{32'hFE000EE3, 32'h5,  32'h6,  1'b0, 5'd0,  32'h0,        32'hFFFFFFFC, 32'h0,  32'h0,        1'b0, 1'b0}; // beq x0,x0,-4
    vt[7]  = '{32'h12345537, 32'h1,  32'h2,  1'b0, 5'd0,  32'h0,        32'h12345000, 32'h1,  32'h2,        1'b1, 1'b0}; // lui x10
    vt[8]  = '{32'h008000EF, 32'h9,  32'h3,  1'b0, 5'd0,  32'h0,        32'h8,        32'h0,  32'h3,        1'b1, 1'b0}; // jal x1,+8
    vt[9]  = '{32'h00432423, 32'h60, 32'h40, 1'b0, 5'd0,  32'h0,        32'h8,        32'h60, 32'h40,       1'b0, 1'b0}; // sw x4,8(x6)
    vt[10] = '{32'hFFC1A103, 32'h5,  32'h6,  1'b0, 5'd0,  32'h0,        32'hFFFFFFFC, 32'h5,  32'h6,        1'b1, 1'b0}; // lw x2,-4(x3)
    vt[11] = '{32'hFFFFF297, 32'h7,  32'h8,  1'b1, 5'd31, 32'hCAFE,     32'hFFFFF000, 32'hCAFE, 32'hCAFE,   1'b1, 1'b0}; // auipc x5 + bypass x31

    opc_pool = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17, 7'h7F};

    idle_inputs();
    ex_ready = 1'b1;
    reset = 1'b1;
    m = '{default: '0};
    #12;
    check_state(1'b1);
    chk("if_ready_in_reset", 32'(if_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors streamed back to back with execute always ready.
    for (int i = 0; i < 12; i++) begin
      if_valid = 1; ex_ready = 1; flush = 0;
      if_instr = vt[i].instr; if_pc = 32'h100 + 32'(i) * 4;
      rf_read_data_1 = vt[i].rd1; rf_read_data_2 = vt[i].rd2;
      wb_write_enable = vt[i].wbe; wb_write_reg = vt[i].wbr; wb_write_data = vt[i].wbd;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'h1);
      chk($sformatf("vec%0d_imm", i), ex_imm, vt[i].e_imm);
      chk($sformatf("vec%0d_rs1_data", i), ex_rs1_data, vt[i].e_rs1d);
      chk($sformatf("vec%0d_rs2_data", i), ex_rs2_data, vt[i].e_rs2d);
      chk($sformatf("vec%0d_reg_write", i), 32'(ex_reg_write), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d_illegal", i), 32'(ex_illegal), 32'(vt[i].e_ill));
    end
    chk("vec0_pc_first", 32'h100, 32'h100 + 0);

    // Stall refresh: hold sw x4,8(x6) three cycles, write back x4 in cycle 2.
    idle_inputs(); if_valid = 1; ex_ready = 1;
    if_instr = 32'h00432423; if_pc = 32'h200; rf_read_data_1 = 32'h60; rf_read_data_2 = 32'h40;
    tick();
    ex_ready = 0; if_instr = 32'h00500093; if_pc = 32'h204;
    for (int c = 1; c <= 3; c++) begin
      wb_write_enable = (c == 2); wb_write_reg = 5'd4; wb_write_data = 32'h1234;
      #1 chk($sformatf("stall_if_ready_c%0d", c), 32'(if_ready), 32'h0);
      tick();
      chk($sformatf("stall_imm_c%0d", c), ex_imm, 32'h8);
      chk($sformatf("stall_pc_c%0d", c), ex_pc, 32'h200);
      chk($sformatf("stall_rs2_c%0d", c), ex_rs2_data, (c >= 2) ? 32'h1234 : 32'h40);
    end
    idle_inputs(); ex_ready = 1;
    tick();
    chk("drain_valid", 32'(ex_valid), 32'h0);

    // Flush with a held instruction and a new one presented.
    if_valid = 1; if_instr = 32'h00100093; if_pc = 32'h300;
    tick();
    if_instr = 32'h00200113; if_pc = 32'h304; flush = 1;
    #1 chk("flush_if_ready", 32'(if_ready), 32'h1);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    flush = 0; if_valid = 0;
    tick();
    chk("flush_dropped", 32'(ex_valid), 32'h0);

    // Reset while holding an instruction.
    if_valid = 1; ex_ready = 0; if_instr = 32'hFFD08293; if_pc = 32'h400; rf_read_data_1 = 32'h1;
    tick();
    if_valid = 0;
    tick();
    chk("hold_before_reset", 32'(ex_valid), 32'h1);
    #2 reset = 1'b1;
    #1 m = '{default: '0};
    check_state(1'b1);
    #2 reset = 1'b0;
    #1 chk("if_ready_after_reset", 32'(if_ready), 32'h1);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int unsigned n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = opc_pool[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      if_instr = ins;
      if_pc = $urandom;
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 1) != 0);
      flush = ($urandom_range(0, 15) == 0);
      rf_read_data_1 = $urandom; rf_read_data_2 = $urandom;
      wb_write_enable = ($urandom_range(0, 1) != 0);
      wb_write_reg = 5'($urandom_range(0, 3));
      wb_write_data = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
